cxd2545_cmd_rx: RTL and testbench
=================================

# cxd2545_cmd_rx

Parametrised receiver for the CXD2545 serial command port (CLK/DATA/XLAT) and the SENS status output, running on the system clock. Oversamples the asynchronous mechacon lines, assembles variable-length LSB-first commands, and on each XLAT latch pushes the command into a FIFO for the soft-CPU. It also drives SENS from a 16-way status vector selected by the latched command address. It replaces the fixed-width shift/latch path with configurable width, sync depth and buffering, and adds truncation and overflow reporting.

## Interface
Parameters:
- SYNC_STAGES, 3, synchroniser flops per async input (≥2)
- MAX_BITS, 24, widest command held (≥8)
- FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- LEN_W, $clog2(MAX_BITS+1), width of bit-count fields

Ports:
- sclk  in  1  system clock (CPU_CLK)
- reset  in  1  synchronous, active-high
- clk_in  in  1  async serial clock from mechacon
- data_in  in  1  async serial data
- xlat_in  in  1  async latch strobe
- sens_data  in  16  status bits indexed by SENS address
- sens  out  1  registered SENS output
- cmd_data  out  MAX_BITS  FIFO head; bit 0 = first bit received, unused MSBs zero
- cmd_len  out  LEN_W  bits received for head command
- cmd_trunc  out  1  head command lost leading bits
- cmd_valid  out  1  FIFO non-empty
- cmd_ready  in  1  pop head when cmd_valid high
- drop_count  out  8  saturating count of commands dropped on full FIFO

## Operation
- Each of clk_in, data_in, xlat_in passes through SYNC_STAGES flops, then one edge-detect flop. Sync and edge flops for clk_in/xlat_in reset to 1, so idle-high lines give no false edge after reset.
- Rising edge of synced clk_in: shift synced data_in into MSB of the MAX_BITS right-shifting register. bit_cnt increments, saturating at MAX_BITS. A shift when bit_cnt==MAX_BITS sets trunc.
- Rising edge of synced xlat_in with bit_cnt>0:
  - form cmd = shreg >> (MAX_BITS-bit_cnt);
  - push {cmd, bit_cnt, trunc};
  - clear shreg, bit_cnt and trunc.
  - If bit_cnt≥4, sens_sel ← last 4 bits received (cmd[bit_cnt-1:bit_cnt-4]). Otherwise sens_sel is unchanged.
- xlat edge with bit_cnt==0: no push, no state change.
- Simultaneous clk and xlat edge in one cycle: the bit is shifted first and is included in the latched command.
- FIFO full on push: command discarded, drop_count increments (saturates at 255). Push and pop in the same cycle while full: the pop frees a slot and the push is accepted.
- Pop occurs when cmd_valid && cmd_ready. cmd_* outputs are undefined-free: they read zero when empty.
- sens ← sens_data[sens_sel], registered every cycle. Changes in sens_data propagate continuously.
- Reset mid-command: the partial shift is discarded, FIFO is emptied, and sens_sel returns to 0.

## Timing
- Reset values: sens 0, cmd_valid 0, cmd_data 0, cmd_len 0, cmd_trunc 0, drop_count 0, sens_sel 0.
- Pin edge to shift register update: SYNC_STAGES+1 sclk cycles.
- xlat pin rising to cmd_valid (FIFO previously empty): SYNC_STAGES+2 cycles.
- xlat pin rising to new sens value: SYNC_STAGES+3 cycles.
- sens_data change to sens: 1 cycle.
- Pop to next head visible: next cycle.
- Input pulse minimum: high and low each ≥ SYNC_STAGES+1 sclk periods. This is met at 50 MHz with a ~1 MHz mechacon CLK.

## Structure
- The shared package cxd2545_pkg holds:
  - SENS_ADDR_W=4;
  - named SENS address constants (FOK, GFS, COUNT, C2PO positions);
  - command address constants used by the CPU firmware.
- Sub-module cxd2545_cmd_fifo: synchronous FIFO, parametrised width/depth, with full/empty, same-cycle push/pop, and synchronous reset. Top level holds the synchronisers, shift/count logic and SENS mux.

## Test plan
- 8-bit command 0x5A sent LSB first then XLAT -> cmd_valid after SYNC_STAGES+2 cycles, cmd_data=0x00005A, cmd_len=8, trunc=0, sens_sel=5.
- 24-bit command 0x2F0012, then sens_data=16'h0004 -> cmd_len=24, sens_sel=2, sens=1 one cycle later. sens_data=0 -> sens=0 next cycle.
- 28 bits sent -> cmd_len=24, cmd_trunc=1, cmd_data = last 24 bits received.
- Five commands with cmd_ready=0 (depth 4) -> first four held in order, drop_count=1. Pop all four -> cmd_valid falls after fourth pop.
- XLAT with no bits, and reset asserted after 12 bits -> no push, cmd_valid stays 0. After reset, an 8-bit command is received intact.
- CLK and XLAT edges synchronised into the same cycle -> final bit included, cmd_len=8.

Source files
------------

// File: rtl/cxd2545_pkg.sv
// Shared constants for the CXD2545 command port: SENS mux addresses and
// command nibble codes the soft-CPU firmware decodes.
package cxd2545_pkg;

  localparam int SENS_ADDR_W = 4;

  typedef logic [SENS_ADDR_W-1:0] sens_addr_t;

  // Positions in the 16-bit status vector that SENS selects from.
  localparam sens_addr_t SENS_FZC   = 4'h0;
  localparam sens_addr_t SENS_AS    = 4'h1;
  localparam sens_addr_t SENS_TZC   = 4'h2;
  localparam sens_addr_t SENS_FOK   = 4'h3;
  localparam sens_addr_t SENS_GFS   = 4'hA;
  localparam sens_addr_t SENS_COUNT = 4'hC;
  localparam sens_addr_t SENS_C2PO  = 4'hE;

  // Command address nibble (top four bits of every command word).
  typedef enum logic [3:0] {
    CMD_FOCUS       = 4'h0,
    CMD_TRACKING    = 4'h1,
    CMD_TRACK_MODE  = 4'h2,
    CMD_SELECT      = 4'h3,
    CMD_AUTO_SEQ    = 4'h4,
    CMD_BLIND_BRAKE = 4'h5,
    CMD_KICK_FZ     = 4'h6,
    CMD_MODE        = 4'h8,
    CMD_FUNC        = 4'h9,
    CMD_AUDIO       = 4'hA,
    CMD_TRAVERSE    = 4'hB,
    CMD_SPINDLE     = 4'hE
  } cmd_addr_e;

endpackage

// File: rtl/cxd2545_cmd_fifo.sv
// Synchronous FIFO with first-word fall-through head. A push while full is
// accepted only when a pop frees the head slot in the same cycle.
module cxd2545_cmd_fifo
  import cxd2545_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are meaningful, and the top masks the head when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cxd2545_cmd_rx.sv
// CXD2545 serial command receiver: synchronises CLK/DATA/XLAT, assembles
// LSB-first commands, queues them for the CPU and drives SENS.
module cxd2545_cmd_rx
  import cxd2545_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int MAX_BITS    = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int LEN_W       = $clog2(MAX_BITS + 1)
) (
  input  logic                sclk,
  input  logic                reset,
  input  logic                clk_in,
  input  logic                data_in,
  input  logic                xlat_in,
  input  logic [15:0]         sens_data,
  output logic                sens,
  output logic [MAX_BITS-1:0] cmd_data,
  output logic [LEN_W-1:0]    cmd_len,
  output logic                cmd_trunc,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [7:0]          drop_count
);

  localparam int               ENTRY_W  = MAX_BITS + LEN_W + 1;
  localparam logic [LEN_W-1:0] FULL_CNT = LEN_W'(MAX_BITS);

  logic [SYNC_STAGES-1:0] clk_sync_q,  clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic [SYNC_STAGES-1:0] xlat_sync_q, xlat_sync_d;
  logic                   clk_prev_q,  clk_prev_d;
  logic                   xlat_prev_q, xlat_prev_d;
  logic                   clk_s, data_s, xlat_s, clk_rise, xlat_rise;

  logic [MAX_BITS-1:0]    shreg_q, shreg_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic                   trunc_q, trunc_d;

  logic                   lat_valid_q, lat_valid_d;
  logic [ENTRY_W-1:0]     lat_entry_q, lat_entry_d;
  sens_addr_t             lat_sel_q, lat_sel_d;
  logic                   lat_sel_ok_q, lat_sel_ok_d;

  sens_addr_t             sens_sel_q, sens_sel_d;
  logic                   sens_q, sens_d;
  logic [7:0]             drop_q, drop_d;

  logic [ENTRY_W-1:0]     head;
  logic                   fifo_full, fifo_empty, pop_fire;

  assign clk_s     = clk_sync_q[SYNC_STAGES-1];
  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign xlat_s    = xlat_sync_q[SYNC_STAGES-1];
  assign clk_rise  = clk_s & ~clk_prev_q;
  assign xlat_rise = xlat_s & ~xlat_prev_q;

  // Synchroniser chains and edge-detect history.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0],  clk_in};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], data_in};
    xlat_sync_d = {xlat_sync_q[SYNC_STAGES-2:0], xlat_in};
    clk_prev_d  = clk_s;
    xlat_prev_d = xlat_s;
  end

  // Shift/count on CLK, then capture on XLAT so a coincident bit is included.
  // NOTE: every variable gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    trunc_d      = trunc_q;
    lat_valid_d  = 1'b0;
    lat_entry_d  = lat_entry_q;
    lat_sel_d    = lat_sel_q;
    lat_sel_ok_d = 1'b0;
    if (clk_rise) begin
      shreg_d = {data_s, shreg_q[MAX_BITS-1:1]};
      if (cnt_q == FULL_CNT) trunc_d = 1'b1;
      else                   cnt_d   = cnt_q + 1'b1;
    end
    if (xlat_rise && (cnt_d != '0)) begin
      lat_valid_d  = 1'b1;
      lat_entry_d  = {trunc_d, cnt_d, shreg_d >> (FULL_CNT - cnt_d)};
      // Newest bit sits at the MSB, so the top nibble is the last four bits.
      lat_sel_d    = shreg_d[MAX_BITS-1 -: SENS_ADDR_W];
      lat_sel_ok_d = (cnt_d >= LEN_W'(SENS_ADDR_W));
      shreg_d      = '0;
      cnt_d        = '0;
      trunc_d      = 1'b0;
    end
  end

  assign pop_fire = !fifo_empty && cmd_ready;

  // SENS address update, SENS mux and drop counter.
  always_comb begin
    sens_sel_d = sens_sel_q;
    drop_d     = drop_q;
    if (lat_valid_q && lat_sel_ok_q) sens_sel_d = lat_sel_q;
    sens_d = sens_data[sens_sel_q];
    if (lat_valid_q && fifo_full && !pop_fire && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;
  end

  // State registers; CLK/XLAT history resets high so idle-high lines give no edge.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge sclk) begin
    if (reset) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '0;
      xlat_sync_q  <= '1;
      clk_prev_q   <= 1'b1;
      xlat_prev_q  <= 1'b1;
      shreg_q      <= '0;
      cnt_q        <= '0;
      trunc_q      <= 1'b0;
      lat_valid_q  <= 1'b0;
      lat_entry_q  <= '0;
      lat_sel_q    <= '0;
      lat_sel_ok_q <= 1'b0;
      sens_sel_q   <= '0;
      sens_q       <= 1'b0;
      drop_q       <= '0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      xlat_sync_q  <= xlat_sync_d;
      clk_prev_q   <= clk_prev_d;
      xlat_prev_q  <= xlat_prev_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      trunc_q      <= trunc_d;
      lat_valid_q  <= lat_valid_d;
      lat_entry_q  <= lat_entry_d;
      lat_sel_q    <= lat_sel_d;
      lat_sel_ok_q <= lat_sel_ok_d;
      sens_sel_q   <= sens_sel_d;
      sens_q       <= sens_d;
      drop_q       <= drop_d;
    end
  end

  cxd2545_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sclk),
    .reset     (reset),
    .push      (lat_valid_q),
    .push_data (lat_entry_q),
    .pop       (cmd_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head is masked to zero when empty so unwritten storage never shows.
  assign cmd_valid                      = !fifo_empty;
  assign {cmd_trunc, cmd_len, cmd_data} = fifo_empty ? '0 : head;
  assign sens                           = sens_q;
  assign drop_count                     = drop_q;

endmodule

// File: tb/tb_cxd2545_cmd_rx.sv
// Randomised scoreboard bench for cxd2545_cmd_rx.
module tb_cxd2545_cmd_rx;

  localparam int S    = 3;
  localparam int MB   = 24;
  localparam int FD   = 4;
  localparam int LW   = $clog2(MB + 1);
  localparam int HALF = S + 2;

  logic          sclk = 1'b0;
  logic          reset, clk_in, data_in, xlat_in, cmd_ready;
  logic [15:0]   sens_data;
  logic          sens, cmd_trunc, cmd_valid;
  logic [MB-1:0] cmd_data;
  logic [LW-1:0] cmd_len;
  logic [7:0]    drop_count;

  typedef struct {
    logic [MB-1:0] data;
    int            len;
    bit            trunc;
  } exp_t;

  exp_t exp_q[$];
  bit   cur_bits[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_drops;
  int   exp_sel;
  bit   rand_ready = 1'b0;

  always #5 sclk = ~sclk;

  cxd2545_cmd_rx #(
    .SYNC_STAGES (S),
    .MAX_BITS    (MB),
    .FIFO_DEPTH  (FD)
  ) dut (
    .sclk       (sclk),
    .reset      (reset),
    .clk_in     (clk_in),
    .data_in    (data_in),
    .xlat_in    (xlat_in),
    .sens_data  (sens_data),
    .sens       (sens),
    .cmd_data   (cmd_data),
    .cmd_len    (cmd_len),
    .cmd_trunc  (cmd_trunc),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .drop_count (drop_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    clk_in  = 1'b0;
    data_in = b;
    wait_cyc(HALF);
    clk_in  = 1'b1;
    cur_bits.push_back(b);
    wait_cyc(HALF);
  endtask

  // Reference model of one latch: keep the newest MB bits, LSB = oldest kept.
  task automatic model_latch();
    int   n, l;
    exp_t e;
    n = cur_bits.size();
    if (n == 0) return;
    l       = (n > MB) ? MB : n;
    e.data  = '0;
    e.len   = l;
    e.trunc = (n > MB);
    for (int i = 0; i < l; i++) e.data[i] = cur_bits[n - l + i];
    if (n >= 4) begin
      exp_sel = 0;
      for (int k = 0; k < 4; k++) exp_sel += int'(cur_bits[n - 1 - k]) << (3 - k);
    end
    if (exp_q.size() >= FD) begin
      if (exp_drops < 255) exp_drops++;
    end else begin
      exp_q.push_back(e);
    end
    cur_bits.delete();
  endtask

  task automatic latch();
    xlat_in = 1'b0;
    wait_cyc(HALF);
    model_latch();
    xlat_in = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic send_cmd(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
    latch();
  endtask

  task automatic check_sens();
    wait_cyc(2);
    sens_data = 16'($urandom);
    wait_cyc(1);
    check("sens_mux", sens, sens_data[exp_sel]);
  endtask

  task automatic drain();
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(negedge sclk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d entries still expected", exp_q.size());
      exp_q.delete();
    end
    wait_cyc(1);
    check("valid_after_drain", cmd_valid, 0);
    check("data_zero_when_empty", {cmd_trunc, cmd_len, cmd_data}, 0);
  endtask

  // Scoreboard monitor: compare the head on every cycle it will be popped.
  always @(negedge sclk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_cmd: data 0x%0h len %0d with nothing expected", cmd_data, cmd_len);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("cmd_data",  cmd_data,  e.data);
        check("cmd_len",   cmd_len,   e.len);
        check("cmd_trunc", cmd_trunc, e.trunc);
      end
    end
  end

  always @(posedge sclk) begin
    if (rand_ready) begin
      #1;
      cmd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            cv_lat, s_lat;
    logic [31:0]   v;
    reset = 1'b1; clk_in = 1'b1; data_in = 1'b0; xlat_in = 1'b1;
    cmd_ready = 1'b0; sens_data = '0; exp_sel = 0; exp_drops = 0;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(2);

    check("rst_sens",  sens, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_data",  cmd_data, 0);
    check("rst_len",   cmd_len, 0);
    check("rst_trunc", cmd_trunc, 0);
    check("rst_drop",  drop_count, 0);

    // 0x5A, 8 bits, with latency of cmd_valid and sens measured from XLAT pin.
    sens_data = 16'h0020;
    v = 32'h5A;
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    xlat_in = 1'b0;
    wait_cyc(HALF);
    model_latch();
    xlat_in = 1'b1;
    cv_lat = -1;
    s_lat  = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge sclk); #1;
      if (cmd_valid && cv_lat < 0) cv_lat = c;
      if (sens && s_lat < 0)       s_lat  = c;
    end
    check("lat_xlat_to_valid", cv_lat, S + 2);
    check("lat_xlat_to_sens",  s_lat,  S + 3);
    check("sel_5a", exp_sel, 5);
    cmd_ready = 1'b1;
    drain();
    check_sens();

    // Full-width command; SENS follows sens_data within one cycle.
    send_cmd(32'h2F0012, 24);
    wait_cyc(2);
    sens_data = 16'h0004;
    wait_cyc(1);
    check("sens_bit2_high", sens, 1);
    sens_data = 16'h0000;
    wait_cyc(1);
    check("sens_bit2_low", sens, 0);
    drain();

    // 28 bits: oldest four bits lost, truncation flagged.
    send_cmd($urandom & 32'h0FFF_FFFF, 28);
    drain();
    check_sens();

    // Five commands with no pops: fifth dropped.
    cmd_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_cmd($urandom, $urandom_range(4, 24));
    wait_cyc(2);
    check("drop_count_full", drop_count, exp_drops);
    check("valid_while_full", cmd_valid, 1);
    cmd_ready = 1'b1;
    drain();

    // Nonzero SENS address, then XLAT with no bits, then reset mid-command.
    send_cmd(32'hF3, 8);
    drain();
    latch();
    wait_cyc(10);
    check("no_bits_no_push", cmd_valid, 0);
    for (int i = 0; i < 12; i++) send_bit(1'($urandom));
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    cur_bits.delete();
    exp_sel   = 0;
    exp_drops = 0;
    wait_cyc(2);
    check("reset_mid_valid", cmd_valid, 0);
    check("reset_mid_drop",  drop_count, 0);
    sens_data = 16'h0001;
    wait_cyc(1);
    check("reset_sel_zero", sens, 1);
    send_cmd($urandom, 8);
    drain();

    // Last CLK rise and XLAT rise land in the same cycle.
    for (int i = 0; i < 7; i++) send_bit(1'($urandom));
    clk_in  = 1'b0;
    xlat_in = 1'b0;
    data_in = 1'($urandom);
    cur_bits.push_back(data_in);
    wait_cyc(HALF);
    model_latch();
    clk_in  = 1'b1;
    xlat_in = 1'b1;
    wait_cyc(HALF);
    drain();

    // Random lengths and random backpressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      send_cmd($urandom, $urandom_range(1, 30));
      check_sens();
    end
    rand_ready = 1'b0;
    wait_cyc(1);
    cmd_ready = 1'b1;
    drain();
    check("drop_count_random", drop_count, exp_drops);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
